// File: rtl/fft_quad_pkg.sv
// Shared types and defaults for the quad-lane FFT capture controller.
// Optional feature macro: FFT_QUAD_CTRL_TIMEOUT_EN (drain timeout).
package fft_quad_pkg;

    localparam int unsigned DEF_INPUT_WIDTH    = 14;
    localparam int unsigned DEF_FRAME_LEN_LOG2 = 14;
    localparam int unsigned DEF_NFRAME_W       = 16;
    localparam int unsigned DEF_SAMPLE_W       = 2 * DEF_INPUT_WIDTH;
    localparam int unsigned DRAIN_TMR_W        = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One sample is an I/Q pair packed side by side.
    function automatic int unsigned sample_w(input int unsigned input_width);
        return 2 * input_width;
    endfunction

endpackage

// File: rtl/fft_quad_frame_cnt.sv
// Per-lane sample position counter, frame-last generation and
// saturating count of completed frames.
module fft_quad_frame_cnt
    import fft_quad_pkg::*;
#(
    parameter int unsigned FRAME_LEN_LOG2 = DEF_FRAME_LEN_LOG2,
    parameter int unsigned NFRAME_W       = DEF_NFRAME_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      beat,
    output logic [FRAME_LEN_LOG2-1:0] sample_cnt,
    output logic                      frame_last,
    output logic [NFRAME_W-1:0]       frames_in
);

    logic [FRAME_LEN_LOG2-1:0] sample_cnt_q, sample_cnt_d;
    logic [NFRAME_W-1:0]       frames_in_q, frames_in_d;

    // Advance the sample position on each accepted beat; the frame closes
    // when the last position is consumed, and the counter wraps to zero.
    always_comb begin
        frame_last   = beat && (sample_cnt_q == '1);
        sample_cnt_d = sample_cnt_q;
        frames_in_d  = frames_in_q;
        if (clear) begin
            sample_cnt_d = '0;
            frames_in_d  = '0;
        end else if (beat) begin
            sample_cnt_d = sample_cnt_q + {{(FRAME_LEN_LOG2-1){1'b0}}, 1'b1};
            if (frame_last && (frames_in_q != '1)) begin
                frames_in_d = frames_in_q + {{(NFRAME_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sample_cnt_q <= '0;
            frames_in_q  <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            frames_in_q  <= frames_in_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign frames_in  = frames_in_q;

endmodule

// File: rtl/fft_quad_ctrl.sv
// Capture sequencer feeding four FFT lanes from a non-stallable ADC stream.
// Optional feature macro: FFT_QUAD_CTRL_TIMEOUT_EN adds a 24-bit drain
// timer and the sticky timeout output.
//
// The frame-closing beat is still on the output register for one cycle
// after it is accepted, so RUN holds for that cycle (drain_req) before
// DRAIN is entered; fft_valid therefore never overlaps DRAIN.
module fft_quad_ctrl
    import fft_quad_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH    = DEF_INPUT_WIDTH,
    parameter int unsigned FRAME_LEN_LOG2 = DEF_FRAME_LEN_LOG2,
    parameter int unsigned NFRAME_W       = DEF_NFRAME_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [2*INPUT_WIDTH-1:0] s_data_0,
    input  logic [2*INPUT_WIDTH-1:0] s_data_1,
    input  logic [2*INPUT_WIDTH-1:0] s_data_2,
    input  logic [2*INPUT_WIDTH-1:0] s_data_3,
    input  logic                     s_valid,
    output logic [2*INPUT_WIDTH-1:0] fft_data_0,
    output logic [2*INPUT_WIDTH-1:0] fft_data_1,
    output logic [2*INPUT_WIDTH-1:0] fft_data_2,
    output logic [2*INPUT_WIDTH-1:0] fft_data_3,
    output logic                     fft_valid,
    output logic                     fft_last,
    input  logic                     fft_ready,
    input  logic                     res_valid,
    input  logic                     res_last,
    input  logic                     start,
    input  logic                     stop,
    input  logic [NFRAME_W-1:0]      num_frames,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
`ifdef FFT_QUAD_CTRL_TIMEOUT_EN
    output logic                     timeout,
`endif
    output logic [NFRAME_W-1:0]      frames_in,
    output logic [NFRAME_W-1:0]      frames_out
);

    localparam int unsigned SW = sample_w(INPUT_WIDTH);

    state_e                    state_q, state_d;
    logic [NFRAME_W-1:0]       nf_q, nf_d;
    logic                      stop_pend_q, stop_pend_d;
    logic                      drain_req_q, drain_req_d;
    logic                      ovf_q, ovf_d;
    logic [NFRAME_W-1:0]       fout_q, fout_d;
    logic                      fv_q, fv_d;
    logic                      fl_q, fl_d;
    logic [3:0][SW-1:0]        data_q, data_d;

    logic [FRAME_LEN_LOG2-1:0] sample_cnt;
    logic                      frame_last;
    logic [NFRAME_W:0]         fin_inc;
    logic                      start_take, run_open, stop_now;
    logic                      accept, drop, count_hit, tmr_expire;

    assign start_take = (state_q == ST_IDLE) && start;
    assign run_open   = (state_q == ST_RUN) && !drain_req_q;
    // A stop at a frame boundary ends capture at once and takes no beat.
    assign stop_now   = run_open && stop && (sample_cnt == '0);
    assign accept     = run_open && !stop_now && s_valid && fft_ready;
    assign drop       = run_open && !stop_now && s_valid && !fft_ready;
    assign fin_inc    = {1'b0, frames_in} + {{NFRAME_W{1'b0}}, 1'b1};
    assign count_hit  = (nf_q != '0) && (fin_inc == {1'b0, nf_q});

    fft_quad_frame_cnt #(
        .FRAME_LEN_LOG2 (FRAME_LEN_LOG2),
        .NFRAME_W       (NFRAME_W)
    ) u_frame_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (start_take),
        .beat       (accept),
        .sample_cnt (sample_cnt),
        .frame_last (frame_last),
        .frames_in  (frames_in)
    );

`ifdef FFT_QUAD_CTRL_TIMEOUT_EN
    logic [DRAIN_TMR_W-1:0] tmr_q, tmr_d;
    logic                   to_q, to_d;

    // Drain timer counts only while draining; expiry forces completion.
    always_comb begin
        tmr_d      = (state_q == ST_DRAIN) ? tmr_q + 24'd1 : '0;
        tmr_expire = (state_q == ST_DRAIN) && (tmr_q == '1) && (fout_q != frames_in);
        to_d       = start_take ? 1'b0 : (to_q | tmr_expire);
    end

    // Drain timer and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign tmr_expire = 1'b0;
`endif

    // Sequencing: start latches the request, frame closes or stop end RUN,
    // returned results end DRAIN.
    always_comb begin
        state_d     = state_q;
        nf_d        = nf_q;
        stop_pend_d = stop_pend_q;
        drain_req_d = drain_req_q;
        ovf_d       = ovf_q | drop;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    nf_d        = num_frames;
                    stop_pend_d = 1'b0;
                    drain_req_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (drain_req_q) begin
                    state_d     = ST_DRAIN;
                    drain_req_d = 1'b0;
                end else if (stop_now) begin
                    state_d     = ST_DRAIN;
                    stop_pend_d = 1'b0;
                end else if (frame_last && (count_hit || stop_pend_q || stop)) begin
                    drain_req_d = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fout_q == frames_in) begin
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result-frame counter and the registered lane forward path.
    always_comb begin
        fout_d = fout_q;
        if (start_take) begin
            fout_d = '0;
        end else if (res_valid && res_last && (fout_q != '1)) begin
            fout_d = fout_q + {{(NFRAME_W-1){1'b0}}, 1'b1};
        end
        fv_d   = accept;
        fl_d   = frame_last;
        data_d = accept ? {s_data_3, s_data_2, s_data_1, s_data_0} : data_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            nf_q        <= '0;
            stop_pend_q <= 1'b0;
            drain_req_q <= 1'b0;
            ovf_q       <= 1'b0;
            fout_q      <= '0;
            fv_q        <= 1'b0;
            fl_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            nf_q        <= nf_d;
            stop_pend_q <= stop_pend_d;
            drain_req_q <= drain_req_d;
            ovf_q       <= ovf_d;
            fout_q      <= fout_d;
            fv_q        <= fv_d;
            fl_q        <= fl_d;
            data_q      <= data_d;
        end
    end

    assign fft_data_0 = data_q[0];
    assign fft_data_1 = data_q[1];
    assign fft_data_2 = data_q[2];
    assign fft_data_3 = data_q[3];
    assign fft_valid  = fv_q;
    assign fft_last   = fl_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign overflow   = ovf_q;
    assign frames_out = fout_q;

endmodule

// File: tb/tb_fft_quad_ctrl.sv
// Directed-sequence bench for fft_quad_ctrl with random sample data and
// random valid gaps, checked against a frame-level reference model.
module tb_fft_quad_ctrl;

    localparam int IW  = 14;
    localparam int FL2 = 4;
    localparam int NW  = 16;
    localparam int L   = 16;
    localparam int SW  = 2 * IW;

    typedef logic [4*SW:0] beat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] s_data_0 = '0, s_data_1 = '0, s_data_2 = '0, s_data_3 = '0;
    logic          s_valid = 1'b0;
    logic [SW-1:0] fft_data_0, fft_data_1, fft_data_2, fft_data_3;
    logic          fft_valid, fft_last;
    logic          fft_ready = 1'b1;
    logic          res_valid = 1'b0, res_last = 1'b0;
    logic          start = 1'b0, stop = 1'b0;
    logic [NW-1:0] num_frames = '0;
    logic          busy, done, overflow;
    logic [NW-1:0] frames_in, frames_out;
`ifdef FFT_QUAD_CTRL_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    fft_quad_ctrl #(
        .INPUT_WIDTH    (IW),
        .FRAME_LEN_LOG2 (FL2),
        .NFRAME_W       (NW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_data_0   (s_data_0),
        .s_data_1   (s_data_1),
        .s_data_2   (s_data_2),
        .s_data_3   (s_data_3),
        .s_valid    (s_valid),
        .fft_data_0 (fft_data_0),
        .fft_data_1 (fft_data_1),
        .fft_data_2 (fft_data_2),
        .fft_data_3 (fft_data_3),
        .fft_valid  (fft_valid),
        .fft_last   (fft_last),
        .fft_ready  (fft_ready),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .start      (start),
        .stop       (stop),
        .num_frames (num_frames),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
`ifdef FFT_QUAD_CTRL_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .frames_in  (frames_in),
        .frames_out (frames_out)
    );

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    // Reference model: capture session as a whole, positions as integers.
    bit m_busy = 0, m_cap = 0, m_stop_pend = 0;
    int m_cnt = 0, m_fin = 0, m_fout = 0, m_nf = 0;
    bit bad_valid = 0;
    bit seen_done = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_busy = 0; m_cap = 0; m_stop_pend = 0;
            m_cnt = 0; m_fin = 0; m_fout = 0;
            return;
        end
        if (start && !m_busy) begin
            m_busy = 1; m_cap = 1; m_stop_pend = 0;
            m_cnt = 0; m_fin = 0; m_fout = 0; m_nf = int'(num_frames);
            return;
        end
        if (res_valid && res_last && m_fout < 65535) m_fout++;
        if (!m_cap) return;
        if (stop && m_cnt == 0) begin
            m_cap = 0; m_stop_pend = 0;
            return;
        end
        if (s_valid && fft_ready) begin
            exp_q.push_back({(m_cnt == L - 1), s_data_3, s_data_2, s_data_1, s_data_0});
            m_cnt++;
            if (m_cnt == L) begin
                m_cnt = 0;
                m_fin++;
                if ((m_nf != 0 && m_fin == m_nf) || m_stop_pend || stop) begin
                    m_cap = 0; m_stop_pend = 0;
                end
            end else if (stop) begin
                m_stop_pend = 1;
            end
        end else if (stop) begin
            m_stop_pend = 1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic cyc(input bit v, input bit r, input bit st, input bit sp, input bit rl);
        logic [31:0] r0, r1, r2, r3;
        r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
        s_valid = v; fft_ready = r; start = st; stop = sp;
        res_valid = rl; res_last = rl;
        s_data_0 = r0[SW-1:0]; s_data_1 = r1[SW-1:0];
        s_data_2 = r2[SW-1:0]; s_data_3 = r3[SW-1:0];
        model_step();
        @(posedge clk);
        #1;
        if (fft_valid) obs_q.push_back({fft_last, fft_data_3, fft_data_2, fft_data_1, fft_data_0});
        if (fft_valid && !busy) bad_valid = 1;
        if (done) begin
            seen_done = 1;
            m_busy = 0;
        end
    endtask

    task automatic cmp_beats(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_to_close();
        for (int i = 0; i < 200 && m_cap; i++) cyc(1, 1, 0, 0, 0);
    endtask

    task automatic wait_done(input string tag);
        seen_done = 0;
        for (int i = 0; i < 20 && !seen_done; i++) cyc(0, 1, 0, 0, 0);
        chk({tag, "_done"}, seen_done, 1);
        cyc(0, 1, 0, 0, 0);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_fft_valid", fft_valid, 0);
        chk("rst_fft_last", fft_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frames_in", frames_in, 0);
        chk("rst_frames_out", frames_out, 0);
        chk("rst_fft_data", {fft_data_3, fft_data_2, fft_data_1, fft_data_0}, 0);
        resetn = 1'b1;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // Two frames, continuous input
        num_frames = 16'd2;
        cyc(0, 1, 1, 0, 0);
        chk("s1_busy", busy, 1);
        run_to_close();
        repeat (4) cyc(0, 1, 0, 0, 0);
        chk("s1_drain_busy", busy, 1);
        chk("s1_drain_done", done, 0);
        chk("s1_frames_in", frames_in, 2);
        chk("s1_beats_total", obs_q.size(), 32);
        cmp_beats("s1");
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        chk("s1_frames_out", frames_out, m_fout);
        wait_done("s1");
        chk("s1_final_in", frames_in, 2);
        chk("s1_final_out", frames_out, 2);

        // Back-pressure drops three beats mid-frame
        num_frames = 16'd1;
        cyc(0, 1, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        run_to_close();
        chk("s2_overflow", overflow, 1);
        chk("s2_beats_total", obs_q.size(), 16);
        cmp_beats("s2");
        cyc(0, 1, 0, 0, 1);
        wait_done("s2");
        chk("s2_overflow_sticky", overflow, 1);

        // Continuous mode, stop on beat 5 of frame 3, random valid gaps
        num_frames = 16'd0;
        cyc(0, 1, 1, 0, 0);
        chk("s3_overflow_cleared", overflow, 0);
        for (int i = 0; i < 300 && !(m_fin == 2 && m_cnt == 4); i++)
            cyc(($urandom_range(0, 3) != 0), 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 200 && m_cap; i++)
            cyc(($urandom_range(0, 3) != 0), 1, 0, 0, 0);
        repeat (5) cyc(1, 1, 0, 0, 0);
        chk("s3_frames_in", frames_in, 3);
        chk("s3_beats_total", obs_q.size(), 48);
        cmp_beats("s3");
        repeat (3) cyc(0, 1, 0, 0, 1);
        wait_done("s3");

        // Start and stop together in RUN; start again during DRAIN
        num_frames = 16'd0;
        cyc(0, 1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        run_to_close();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("s4_start_in_drain_busy", busy, 1);
        chk("s4_frames_in", frames_in, 1);
        chk("s4_frames_out", frames_out, 0);
        cmp_beats("s4");
        cyc(0, 1, 0, 0, 1);
        wait_done("s4");
        num_frames = 16'd1;
        cyc(0, 1, 1, 1, 0);
        chk("s4_idle_start_wins", busy, 1);
        run_to_close();
        cmp_beats("s4b");
        cyc(0, 1, 0, 0, 1);
        wait_done("s4b");

        // Reset in the middle of a frame, then a fresh capture
        num_frames = 16'd1;
        cyc(0, 1, 1, 0, 0);
        repeat (7) cyc(1, 1, 0, 0, 0);
        resetn = 1'b0;
        cyc(1, 1, 0, 0, 0);
        chk("s5_rst_valid", fft_valid, 0);
        chk("s5_rst_last", fft_last, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_frames_in", frames_in, 0);
        chk("s5_rst_frames_out", frames_out, 0);
        chk("s5_rst_overflow", overflow, 0);
        chk("s5_rst_data", {fft_data_3, fft_data_2, fft_data_1, fft_data_0}, 0);
        cmp_beats("s5_partial");
        resetn = 1'b1;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        run_to_close();
        chk("s5_beats_total", obs_q.size(), 16);
        cmp_beats("s5");
        cyc(0, 1, 0, 0, 1);
        wait_done("s5");

        chk("valid_only_when_busy", bad_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
